// File: rtl/sdh_tx_arbiter.sv
// sdh_tx_arbiter: round-robin burst scheduler in front of the SDH transmitter
// byte input. Each grant is a burst of SLOT_LEN pops from one channel FIFO;
// IDLE_BYTE is sent whenever no granted byte is due.
// Optional per-channel completed-burst counters: define SDH_ARB_STAT_EN.
module sdh_tx_arbiter #(
  parameter int          NUM_CH    = 4,
  parameter int          SLOT_LEN  = 16,
  parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
  input  logic                 sdh_clk,
  input  logic                 rst_n,
  input  logic                 sdh_tx_din_req,
  output logic [7:0]           sdh_tx_din,
  input  logic [NUM_CH-1:0]    ch_en,
  input  logic [NUM_CH-1:0]    ch_valid,
  output logic [NUM_CH-1:0]    ch_rd,
  input  logic [NUM_CH*8-1:0]  ch_data,
`ifdef SDH_ARB_STAT_EN
  input  logic                 stat_clr,
  output logic [NUM_CH*16-1:0] stat_burst_cnt,
`endif
  output logic                 arb_busy,
  output logic [2:0]           arb_ch,
  output logic                 burst_done
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  // Counter is 9 bits wide so SLOT_LEN up to 256 fits without special cases.
  localparam logic [8:0] LAST_CNT = 9'(SLOT_LEN - 1);
  localparam logic [2:0] RST_CH   = 3'(NUM_CH - 1);

  state_t      state_reg, state_next;
  logic [8:0]  cnt_reg, cnt_next;
  logic [2:0]  arb_ch_reg, arb_ch_next;
  logic        done_reg, done_next;
  logic        sel_valid_reg;
  logic [2:0]  sel_idx_reg;

  // Candidates and FIFO bytes padded to 8 entries so a 3-bit index always fits.
  logic [7:0]  cand_pad;
  logic [7:0]  data_arr [8];
  logic [2:0]  pick_idx;
  logic        pick_found;
  logic        pop;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pad
      if (gi < NUM_CH) begin : g_real
        assign cand_pad[gi] = ch_valid[gi] & ch_en[gi];
        assign data_arr[gi] = ch_data[8*gi +: 8];
      end else begin : g_zero
        assign cand_pad[gi] = 1'b0;
        assign data_arr[gi] = IDLE_BYTE;
      end
    end
  endgenerate

  // Round-robin search: first candidate after arb_ch in cyclic order. The loop
  // runs from the farthest offset down so the nearest hit is the last written.
  always_comb begin
    int         s;
    logic [2:0] c;
    pick_found = 1'b0;
    pick_idx   = arb_ch_reg;
    for (int k = NUM_CH; k >= 1; k--) begin
      s = int'(arb_ch_reg) + k;
      if (s >= NUM_CH) s = s - NUM_CH;
      c = 3'(s);
      if (cand_pad[c]) begin
        pick_found = 1'b1;
        pick_idx   = c;
      end
    end
  end

  assign pop = (state_reg == ST_BURST) && sdh_tx_din_req;

  // State register: reset leaves ch0 as the first channel to be checked.
  always_ff @(posedge sdh_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      arb_ch_reg <= RST_CH;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      arb_ch_reg <= arb_ch_next;
      done_reg   <= done_next;
    end
  end

  // Next-state and pop strobes; pops only happen in BURST and follow req directly.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    arb_ch_next = arb_ch_reg;
    done_next   = 1'b0;
    ch_rd       = '0;
    case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          arb_ch_next = pick_idx;
          cnt_next    = '0;
          state_next  = ST_BURST;
        end
      end
      ST_BURST: begin
        ch_rd = NUM_CH'(pop) << arb_ch_reg;
        if (pop) begin
          cnt_next = cnt_reg + 9'd1;
          if (cnt_reg == LAST_CNT) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Delayed select: remembers which FIFO (if any) was popped last cycle.
  always_ff @(posedge sdh_clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_valid_reg <= 1'b0;
      sel_idx_reg   <= RST_CH;
    end else begin
      sel_valid_reg <= |ch_rd;
      sel_idx_reg   <= arb_ch_reg;
    end
  end

  assign sdh_tx_din = sel_valid_reg ? data_arr[sel_idx_reg] : IDLE_BYTE;
  assign arb_busy   = (state_reg == ST_BURST);
  assign arb_ch     = arb_ch_reg;
  assign burst_done = done_reg;

`ifdef SDH_ARB_STAT_EN
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_stat
      logic [15:0] stat_reg;
      // Saturating completed-burst count; arb_ch still names the finished
      // burst's channel while burst_done is high.
      always_ff @(posedge sdh_clk or negedge rst_n) begin
        if (!rst_n) begin
          stat_reg <= '0;
        end else if (stat_clr) begin
          stat_reg <= '0;
        end else if (done_reg && (arb_ch_reg == 3'(gi)) && (stat_reg != 16'hFFFF)) begin
          stat_reg <= stat_reg + 16'd1;
        end
      end
      assign stat_burst_cnt[16*gi +: 16] = stat_reg;
    end
  endgenerate
`endif

endmodule
